qpsk_mapper: RTL and testbench
==============================

QPSK_MAPPER -- requirements
Module: qpsk_mapper

Interface
REQ-001 SHALL have parameter: sps, 4, samples per symbol; legal range 1..16.
REQ-002 SHALL have parameter: amp, 16'h2000, positive symbol amplitude; legal range 1..16'h7FFF.
REQ-003 SHALL have port: clk  in  1  clock; all state updates on rising edge.
REQ-004 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port: data_i  in  8  input byte.
REQ-006 SHALL have port: data_valid_i  in  1  data_i valid.
REQ-007 SHALL have port: data_ready_o  out  1  block accepts data_i this cycle.
REQ-008 SHALL have port: y_a_o  out  16  I sample, two's complement, to filter x_a_i.
REQ-009 SHALL have port: y_b_o  out  16  Q sample, two's complement, to filter x_b_i.
REQ-010 SHALL have port: y_valid_o  out  1  y_a_o/y_b_o valid.
REQ-011 SHALL have port: y_ready_i  in  1  downstream accepts the sample.

Function
REQ-012 SHALL transfer a byte when data_valid_i & data_ready_o at a rising edge, and a sample when y_valid_o & y_ready_i at a rising edge.
REQ-013 SHALL hold internal state: loaded flag, 8-bit shift register, dibit counter 0..3, phase counter 0..sps-1.
REQ-014 SHALL implement two states: EMPTY (loaded=0) and RUN (loaded=1).
REQ-015 SHALL drive y_valid_o = loaded, from registers only; no combinational path from data_valid_i or y_ready_i to y_valid_o, y_a_o or y_b_o.
REQ-016 SHALL drive data_ready_o = ~loaded | (last sample of byte transfers this cycle); last sample = dibit 3 and phase sps-1.
REQ-017 SHALL consume dibits MSB first: data_i[7:6], [5:4], [3:2], [1:0].
REQ-018 SHALL map dibit bit1 to I and bit0 to Q: bit 0 -> +amp, bit 1 -> -amp (two's complement of amp).
REQ-019 SHALL output the mapped symbol at phase 0 and 16'h0000 on both rails at phases 1..sps-1 (zero-stuffing upsampler).
REQ-020 SHALL drive y_a_o = y_b_o = 0 when y_valid_o = 0.
REQ-021 SHALL, on byte acceptance, load the shift register, set dibit = 0 and phase = 0, and enter RUN; the first sample appears one cycle after the accepting edge.
REQ-022 SHALL, on sample transfer with phase < sps-1, increment phase only.
REQ-023 SHALL, on sample transfer with phase = sps-1 and dibit < 3, clear phase, increment dibit and shift the register left by 2.
REQ-024 SHALL, on transfer of the last sample of a byte, load the new byte if data_valid_i = 1 (staying in RUN, no bubble), otherwise go to EMPTY.
REQ-025 SHALL hold all outputs and state stable while y_valid_o = 1 and y_ready_i = 0.
REQ-026 SHALL emit exactly 4*sps samples per accepted byte; no byte is dropped or duplicated.
REQ-027 SHALL, for sps = 1, output a symbol on every sample with no zero samples.
REQ-028 SHALL ignore data_i when data_ready_o = 0.

Reset
REQ-029 SHALL, while rst = 1, clear loaded, shift register, dibit and phase to 0, regardless of other inputs.
REQ-030 SHALL, in the cycle after rst, drive y_valid_o = 0, y_a_o = y_b_o = 0 and data_ready_o = 1.
REQ-031 SHALL, on rst mid-byte, discard the partial byte; no remaining samples are emitted.

Verification (sps = 4, amp = 16'h2000 unless stated)
REQ-032 SHALL cover: byte 0x1B, y_ready_i = 1 -> I: 2000,0,0,0,2000,0,0,0,E000,0,0,0,E000,0,0,0; Q: 2000,0,0,0,E000,0,0,0,2000,0,0,0,E000,0,0,0; then y_valid_o = 0.
REQ-033 SHALL cover: data_valid_i held 1 with bytes 0x00, 0xFF -> y_valid_o high 32 consecutive cycles; data_ready_o high on the 16th sample transfer; symbols 2000/2000 x4 then E000/E000 x4.
REQ-034 SHALL cover: y_ready_i low 5 cycles at phase 2 of dibit 1 -> y_a_o, y_b_o, y_valid_o unchanged for those cycles; full sample sequence unchanged.
REQ-035 SHALL cover: rst asserted after 6 samples of byte 0x1B -> next cycle y_valid_o = 0, data_ready_o = 1; no further samples until a new byte.
REQ-036 SHALL cover: single byte then data_valid_i = 0 -> exactly 16 valid samples, then y_valid_o = 0 and data_ready_o = 1.
REQ-037 SHALL cover: sps = 1, byte 0xFF -> 4 consecutive samples I = Q = E000, no zeros.

Source files
------------

// File: rtl/qpsk_mapper.sv
// QPSK mapper: splits each input byte into four dibits (MSB first), maps them to
// +/-amp on the I/Q rails and zero-stuffs each symbol out to sps samples.
module qpsk_mapper #(
    parameter int          sps = 4,
    parameter logic [15:0] amp = 16'h2000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  data_i,
    input  logic        data_valid_i,
    output logic        data_ready_o,
    output logic [15:0] y_a_o,
    output logic [15:0] y_b_o,
    output logic        y_valid_o,
    input  logic        y_ready_i
);

    // state | meaning
    // EMPTY | no byte held; waiting for data_valid_i
    // RUN   | emitting the samples of the byte held in shreg
    localparam logic [0:0]  EMPTY   = 1'b0;
    localparam logic [0:0]  RUN     = 1'b1;
    localparam logic [3:0]  PH_LAST = 4'(sps - 1);
    localparam logic [15:0] AMP_NEG = ~amp + 16'd1;

    logic [0:0] state;
    logic [7:0] shreg;
    logic [1:0] dibit;
    logic [3:0] phase;

    logic loaded;
    logic last_sample;
    logic y_xfer;
    logic accept;

    always_comb begin
        loaded       = (state == RUN);
        last_sample  = (dibit == 2'd3) && (phase == PH_LAST);
        y_xfer       = loaded && y_ready_i;
        data_ready_o = !loaded || (y_xfer && last_sample);
        accept       = data_valid_i && data_ready_o;
    end

    // Outputs decode registered state only, so the valid/sample path never
    // sees the handshake inputs combinationally.
    always_comb begin
        y_valid_o = loaded;
        y_a_o     = 16'h0000;
        y_b_o     = 16'h0000;
        if (loaded && (phase == 4'd0)) begin
            y_a_o = shreg[7] ? AMP_NEG : amp;
            y_b_o = shreg[6] ? AMP_NEG : amp;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            shreg <= 8'h00;
            dibit <= 2'd0;
            phase <= 4'd0;
        end else if (accept) begin
            // Also covers back-to-back bytes: the last sample and the new load share an edge.
            state <= RUN;
            shreg <= data_i;
            dibit <= 2'd0;
            phase <= 4'd0;
        end else if (y_xfer) begin
            if (last_sample) begin
                state <= EMPTY;
                dibit <= 2'd0;
                phase <= 4'd0;
            end else if (phase == PH_LAST) begin
                phase <= 4'd0;
                dibit <= dibit + 2'd1;
                shreg <= {shreg[5:0], 2'b00};
            end else begin
                phase <= phase + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_qpsk_mapper.sv
// Bench for qpsk_mapper: a sample-queue model checked every cycle, plus literal
// sequence checks for the directed byte patterns and an sps=1 instance.
module tb_qpsk_mapper;

    localparam int          SPS = 4;
    localparam logic [15:0] AMP = 16'h2000;
    localparam logic [15:0] NEG = 16'hE000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  data = 8'h00;
    logic        data_valid = 1'b0;
    logic        data_ready;
    logic [15:0] y_a, y_b;
    logic        y_valid;
    logic        y_ready = 1'b1;

    logic [7:0]  d1_data = 8'h00;
    logic        d1_valid = 1'b0;
    logic        d1_ready;
    logic [15:0] d1_a, d1_b;
    logic        d1_yvalid;
    logic        d1_yready = 1'b1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    logic [31:0] mq[$];
    logic [31:0] log_q[$];
    int          log_cyc[$];

    always #5 clk = ~clk;

    qpsk_mapper #(.sps(SPS), .amp(AMP)) dut (
        .clk(clk), .rst(rst), .data_i(data), .data_valid_i(data_valid),
        .data_ready_o(data_ready), .y_a_o(y_a), .y_b_o(y_b),
        .y_valid_o(y_valid), .y_ready_i(y_ready)
    );

    qpsk_mapper #(.sps(1), .amp(AMP)) dut1 (
        .clk(clk), .rst(rst), .data_i(d1_data), .data_valid_i(d1_valid),
        .data_ready_o(d1_ready), .y_a_o(d1_a), .y_b_o(d1_b),
        .y_valid_o(d1_yvalid), .y_ready_i(d1_yready)
    );

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic void push_byte(input logic [7:0] b);
        for (int d = 0; d < 4; d++) begin
            int dib;
            logic [15:0] si, sq;
            dib = (int'(b) >> (6 - 2 * d)) & 3;
            si  = (dib & 2) != 0 ? NEG : AMP;
            sq  = (dib & 1) != 0 ? NEG : AMP;
            for (int p = 0; p < SPS; p++)
                mq.push_back(p == 0 ? {si, sq} : 32'h0);
        end
    endfunction

    // Model: the queue holds every sample still owed for accepted bytes.
    always @(posedge clk) begin
        bit rdy;
        rdy = (mq.size() == 0) || (mq.size() == 1 && y_ready);
        if (rst) begin
            mq.delete();
        end else begin
            if (mq.size() > 0 && y_ready) void'(mq.pop_front());
            if (data_valid && rdy) push_byte(data);
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            bit ev, er;
            ev = mq.size() > 0;
            er = (mq.size() == 0) || (mq.size() == 1 && y_ready);
            chk("y_valid", 16'(y_valid), 16'(ev));
            chk("data_ready", 16'(data_ready), 16'(er));
            chk("y_a", y_a, ev ? mq[0][31:16] : 16'h0);
            chk("y_b", y_b, ev ? mq[0][15:0] : 16'h0);
            if (y_valid && y_ready && !rst) begin
                log_q.push_back({y_a, y_b});
                log_cyc.push_back(cyc);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        data = b;
        data_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (data_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL send_timeout got ready 0 expected 1");
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!y_valid) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL idle_timeout got y_valid 1 expected 0");
        end
    endtask

    task automatic wait_log(input int n);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (log_q.size() >= n) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL log_timeout got %0d expected %0d", log_q.size(), n);
        end
    endtask

    // Hand-computed 0x1B stream: dibits 00,01,10,11.
    task automatic check_1b(input string tag);
        logic [15:0] si[4];
        logic [15:0] sq[4];
        si = '{16'h2000, 16'h2000, 16'hE000, 16'hE000};
        sq = '{16'h2000, 16'hE000, 16'h2000, 16'hE000};
        chk({tag, "_len"}, 16'(log_q.size()), 16'd16);
        for (int k = 0; k < 16 && k < log_q.size(); k++) begin
            chk({tag, "_i"}, log_q[k][31:16], (k % 4 == 0) ? si[k / 4] : 16'h0);
            chk({tag, "_q"}, log_q[k][15:0], (k % 4 == 0) ? sq[k / 4] : 16'h0);
        end
    endtask

    initial begin
        logic [15:0] ha, hb;
        logic        hv;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_y_valid", 16'(y_valid), 16'd0);
        chk("rst_ready", 16'(data_ready), 16'd1);

        // Single byte 0x1B, free-running sink, then idle.
        log_q.delete(); log_cyc.delete();
        @(posedge clk); #1;
        send_byte(8'h1B);
        data_valid = 1'b0;
        wait_idle();
        check_1b("b1b");
        chk("idle_ready", 16'(data_ready), 16'd1);

        // Back-to-back 0x00, 0xFF with valid held.
        log_q.delete(); log_cyc.delete();
        @(posedge clk); #1;
        send_byte(8'h00);
        send_byte(8'hFF);
        data_valid = 1'b0;
        wait_idle();
        chk("b2b_len", 16'(log_q.size()), 16'd32);
        for (int k = 1; k < log_q.size(); k++)
            chk("b2b_consec", 16'(log_cyc[k] - log_cyc[k - 1]), 16'd1);
        for (int k = 0; k < log_q.size(); k++) begin
            chk("b2b_i", log_q[k][31:16], (k % 4 != 0) ? 16'h0 : (k < 16 ? AMP : NEG));
            chk("b2b_q", log_q[k][15:0], (k % 4 != 0) ? 16'h0 : (k < 16 ? AMP : NEG));
        end

        // Stall for 5 cycles at dibit 1 phase 2.
        log_q.delete(); log_cyc.delete();
        @(posedge clk); #1;
        send_byte(8'h1B);
        data_valid = 1'b0;
        wait_log(6);
        y_ready = 1'b0;
        ha = y_a; hb = y_b; hv = y_valid;
        chk("stall_v0", 16'(hv), 16'd1);
        repeat (5) begin
            @(negedge clk);
            chk("stall_a", y_a, ha);
            chk("stall_b", y_b, hb);
            chk("stall_v", 16'(y_valid), 16'(hv));
        end
        @(posedge clk); #1;
        y_ready = 1'b1;
        wait_idle();
        check_1b("stall");

        // Reset after 6 samples discards the rest of the byte.
        log_q.delete(); log_cyc.delete();
        @(posedge clk); #1;
        send_byte(8'h1B);
        data_valid = 1'b0;
        wait_log(6);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_valid", 16'(y_valid), 16'd0);
        chk("midrst_ready", 16'(data_ready), 16'd1);
        repeat (10) @(negedge clk);
        chk("midrst_len", 16'(log_q.size()), 16'd6);

        // sps = 1 instance, byte 0xFF: four back-to-back symbols.
        @(posedge clk); #1;
        d1_data = 8'hFF;
        d1_valid = 1'b1;
        @(negedge clk);
        chk("s1_ready", 16'(d1_ready), 16'd1);
        @(posedge clk); #1;
        d1_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("s1_valid", 16'(d1_yvalid), 16'd1);
            chk("s1_i", d1_a, 16'hE000);
            chk("s1_q", d1_b, 16'hE000);
        end
        @(negedge clk);
        chk("s1_end_valid", 16'(d1_yvalid), 16'd0);
        chk("s1_end_ready", 16'(d1_ready), 16'd1);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
